// File: rtl/xfer_arbiter_if.sv
// Handshake and status bundle between the row-transfer arbiter and its
// surroundings: per-core ready/done, remote req/ack, grant/select, error.
interface xfer_arbiter_if;
  logic [1:0] ready;
  logic       ack;
  logic       clr_err;
  logic       req;
  logic [1:0] gnt;
  logic       sel;
  logic [1:0] done;
  logic       busy;
  logic       timeout_err;

  // Arbiter side: owns the request, grant and status outputs.
  modport master (
    input  ready, ack, clr_err,
    output req, gnt, sel, done, busy, timeout_err
  );

  // Environment side: sources, remote core and error supervisor.
  modport slave (
    output ready, ack, clr_err,
    input  req, gnt, sel, done, busy, timeout_err
  );
endinterface

// File: rtl/xfer_arbiter.sv
// Round-robin arbiter for the shared inter-core row-transfer link.
// Picks one ready source, holds the data mux for a settle pause, then runs a
// four-phase req/ack handshake with the remote core under a timeout.
module xfer_arbiter #(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic           clk,
  input  logic           reset,
  xfer_arbiter_if.master link
);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             last_reg, last_next;
  logic             sel_reg, sel_next;
  logic             err_reg, err_next;
  logic [1:0]       done_reg, done_next;
  logic             grant_active;

  // State register; last starts at 1 so core 0 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;
      sel_reg   <= 1'b0;
      err_reg   <= 1'b0;
      done_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: arbitration, settle count, handshake and timeout.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    sel_next   = sel_reg;
    err_next   = err_reg;
    done_next  = 2'b00;

    // Clear first so that a timeout in the same cycle overrides it.
    if (link.clr_err) err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (link.ready != 2'b00) begin
          sel_next   = (link.ready == 2'b11) ? ~last_reg : link.ready[1];
          cnt_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          cnt_next   = '0;
          state_next = WAIT;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      WAIT: begin
        // An ack on the expiry cycle still counts as a good transfer.
        if (link.ack) begin
          done_next  = sel_reg ? 2'b10 : 2'b01;
          last_next  = sel_reg;
          state_next = RELEASE;
        end else if (TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST)) begin
          err_next   = 1'b1;
          last_next  = sel_reg;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      RELEASE: begin
        if (!link.ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant_active = (state_reg == SETUP) || (state_reg == WAIT);

  // One-hot grant decoded from the registered select.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
      assign link.gnt[gi] = grant_active && (sel_reg == 1'(gi));
    end
  endgenerate

  assign link.req         = (state_reg == WAIT);
  assign link.sel         = sel_reg;
  assign link.done        = done_reg;
  assign link.busy        = (state_reg != IDLE);
  assign link.timeout_err = err_reg;

endmodule

// File: tb/tb_xfer_arbiter.sv
// Directed self-checking bench for xfer_arbiter (SETUP_CYC=4, TIMEOUT=16).
// Cycle numbers in comments count from the cycle in which ready is applied.
module tb_xfer_arbiter;
  logic clk;
  logic reset;
  int   passed;
  int   total;
  bit   auto_ack;
  logic req_d;

  xfer_arbiter_if bus();

  xfer_arbiter #(.SETUP_CYC(4), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .link  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample 1 time unit after the edge. The optional remote
  // responder raises ack one cycle after req rises and drops it with req.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) bus.ack = bus.req & req_d;
    req_d = bus.req;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 60) begin
      tick();
      k++;
    end
    total++;
    if (bus.busy !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b want 0", name, bus.busy);
    else passed++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.ready = 2'b00; bus.ack = 1'b0; bus.clr_err = 1'b0;
    auto_ack = 1'b0; req_d = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    tick();
    total++; if (bus.req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.req); else passed++;
    total++; if (bus.gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", bus.gnt); else passed++;
    total++; if (bus.done !== 2'b00) $display("FAIL reset_done: got %b want 00", bus.done); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.timeout_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.timeout_err); else passed++;
    total++; if (bus.sel !== 1'b0) $display("FAIL reset_sel: got %b want 0", bus.sel); else passed++;
    reset = 1'b1;
    tick();
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_single();
    bus.ready = 2'b01; auto_ack = 1'b1;          // cycle 0
    tick();                                        // cycle 1
    total++; if (bus.gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", bus.gnt); else passed++;
    total++; if (bus.sel !== 1'b0) $display("FAIL single_sel: got %b want 0", bus.sel); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else passed++;
    bus.ready = 2'b00;
    repeat (3) tick();                             // cycle 4
    total++; if (bus.req !== 1'b0) $display("FAIL single_req_early: got %b want 0", bus.req); else passed++;
    tick();                                        // cycle 5
    total++; if (bus.req !== 1'b1) $display("FAIL single_req_rise: got %b want 1", bus.req); else passed++;
    tick(); tick();                                // cycle 7
    total++; if (bus.done !== 2'b01) $display("FAIL single_done: got %b want 01", bus.done); else passed++;
    total++; if (bus.req !== 1'b0) $display("FAIL single_req_fall: got %b want 0", bus.req); else passed++;
    total++; if (bus.gnt !== 2'b00) $display("FAIL single_gnt_fall: got %b want 00", bus.gnt); else passed++;
    tick();                                        // cycle 8
    total++; if (bus.done !== 2'b00) $display("FAIL single_done_pulse: got %b want 00", bus.done); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", bus.busy); else passed++;
    $display("test_single: core 0 transfer");
  endtask

  task automatic test_round_robin();
    logic [1:0] g [8];
    int         c [8];
    int         n;
    logic [1:0] prev;
    do_reset();
    bus.ready = 2'b11; auto_ack = 1'b1;
    n = 0; prev = 2'b00;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (bus.gnt !== 2'b00 && prev === 2'b00 && n < 8) begin
        g[n] = bus.gnt; c[n] = cyc; n++;
      end
      prev = bus.gnt;
    end
    bus.ready = 2'b00;
    total++; if (n !== 4) $display("FAIL rr_count: got %0d want 4", n); else passed++;
    if (n >= 4) begin
      total++; if (c[0] !== 1) $display("FAIL rr_first_cycle: got %0d want 1", c[0]); else passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (g[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10))
          $display("FAIL rr_gnt%0d: got %b want %b", i, g[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        else passed++;
      end
      for (int i = 1; i < 4; i++) begin
        total++;
        if (c[i] - c[i-1] !== 8) $display("FAIL rr_spacing%0d: got %0d want 8", i, c[i] - c[i-1]);
        else passed++;
      end
    end
    wait_idle("rr");
    $display("test_round_robin: %0d grants observed", n);
  endtask

  task automatic test_timeout();
    int cnt;
    bit saw_done;
    auto_ack = 1'b0; bus.ack = 1'b0;
    bus.ready = 2'b11;                             // cycle 0, last = core 1
    tick();                                        // cycle 1
    total++; if (bus.gnt !== 2'b01) $display("FAIL to_gnt0: got %b want 01", bus.gnt); else passed++;
    repeat (4) tick();                             // cycle 5
    cnt = 0; saw_done = 1'b0;
    while (bus.req === 1'b1 && cnt < 40) begin
      cnt++;
      if (bus.done !== 2'b00) saw_done = 1'b1;
      tick();
    end                                            // cycle 21
    total++; if (cnt !== 16) $display("FAIL to_req_len: got %0d want 16", cnt); else passed++;
    total++; if (saw_done !== 1'b0) $display("FAIL to_done_during_wait: got %b want 0", saw_done); else passed++;
    total++; if (bus.timeout_err !== 1'b1) $display("FAIL to_err: got %b want 1", bus.timeout_err); else passed++;
    total++; if (bus.done !== 2'b00) $display("FAIL to_no_done: got %b want 00", bus.done); else passed++;
    tick(); tick();                                // cycle 23
    total++; if (bus.gnt !== 2'b10) $display("FAIL to_next_gnt: got %b want 10", bus.gnt); else passed++;
    bus.ready = 2'b00; bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    total++; if (bus.timeout_err !== 1'b0) $display("FAIL to_clr: got %b want 0", bus.timeout_err); else passed++;
    auto_ack = 1'b1;
    wait_idle("to");
    auto_ack = 1'b0;
    $display("test_timeout: req held %0d cycles", cnt);
  endtask

  task automatic test_ack_at_expiry();
    bus.ack = 1'b0;
    bus.ready = 2'b01;                             // cycle 0
    tick();
    bus.ready = 2'b00;
    repeat (19) tick();                            // cycle 20, last WAIT cycle
    total++; if (bus.req !== 1'b1) $display("FAIL exp_req: got %b want 1", bus.req); else passed++;
    bus.ack = 1'b1;
    tick();
    total++; if (bus.done !== 2'b01) $display("FAIL exp_done: got %b want 01", bus.done); else passed++;
    total++; if (bus.timeout_err !== 1'b0) $display("FAIL exp_err: got %b want 0", bus.timeout_err); else passed++;
    bus.ack = 1'b0;
    wait_idle("exp");
    $display("test_ack_at_expiry: ack wins over timeout");
  endtask

  task automatic test_clr_on_expiry();
    bus.ready = 2'b01;                             // cycle 0
    tick();
    bus.ready = 2'b00;
    repeat (19) tick();                            // cycle 20
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    total++; if (bus.timeout_err !== 1'b1) $display("FAIL clrexp_err: got %b want 1", bus.timeout_err); else passed++;
    total++; if (bus.done !== 2'b00) $display("FAIL clrexp_done: got %b want 00", bus.done); else passed++;
    wait_idle("clrexp");
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    $display("test_clr_on_expiry: set beats clear");
  endtask

  task automatic test_async_reset();
    bus.ready = 2'b11;                             // cycle 0, last = core 0
    tick();
    total++; if (bus.gnt !== 2'b10) $display("FAIL ar_gnt_pre: got %b want 10", bus.gnt); else passed++;
    repeat (4) tick();                             // cycle 5, WAIT
    total++; if (bus.req !== 1'b1) $display("FAIL ar_req_pre: got %b want 1", bus.req); else passed++;
    #3 reset = 1'b0;
    #1;
    total++; if (bus.req !== 1'b0) $display("FAIL ar_req: got %b want 0", bus.req); else passed++;
    total++; if (bus.gnt !== 2'b00) $display("FAIL ar_gnt: got %b want 00", bus.gnt); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", bus.busy); else passed++;
    tick();
    reset = 1'b1;
    tick();
    total++; if (bus.gnt !== 2'b01) $display("FAIL ar_first_gnt: got %b want 01", bus.gnt); else passed++;
    bus.ready = 2'b00; auto_ack = 1'b1;
    wait_idle("ar");
    auto_ack = 1'b0; bus.ack = 1'b0;
    $display("test_async_reset: reset mid-WAIT");
  endtask

  task automatic test_ready_drop_hold();
    bus.ready = 2'b10;                             // cycle 0
    tick();                                        // cycle 1
    total++; if (bus.sel !== 1'b1) $display("FAIL hold_sel: got %b want 1", bus.sel); else passed++;
    bus.ready = 2'b00;
    repeat (3) tick();                             // cycle 4
    bus.ack = 1'b1;
    tick();                                        // cycle 5
    total++; if (bus.req !== 1'b1) $display("FAIL hold_req: got %b want 1", bus.req); else passed++;
    tick();                                        // cycle 6
    total++; if (bus.req !== 1'b0) $display("FAIL hold_req_one: got %b want 0", bus.req); else passed++;
    total++; if (bus.done !== 2'b10) $display("FAIL hold_done: got %b want 10", bus.done); else passed++;
    for (int i = 0; i < 10; i++) begin
      tick();                                      // cycles 7..16
      total++; if (bus.busy !== 1'b1) $display("FAIL hold_busy%0d: got %b want 1", i, bus.busy); else passed++;
      total++; if (bus.done !== 2'b00) $display("FAIL hold_done%0d: got %b want 00", i, bus.done); else passed++;
    end
    bus.ack = 1'b0;
    tick();                                        // cycle 17
    total++; if (bus.busy !== 1'b0) $display("FAIL hold_release: got %b want 0", bus.busy); else passed++;
    $display("test_ready_drop_hold: release waits for ack low");
  endtask

  initial begin
    passed = 0; total = 0;
    reset = 1'b0;
    bus.ready = 2'b00; bus.ack = 1'b0; bus.clr_err = 1'b0;
    auto_ack = 1'b0; req_d = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_ack_at_expiry();
    test_clr_on_expiry();
    test_async_reset();
    test_ready_drop_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/xfer_arbiter.md
# xfer_arbiter

Arbitrates the shared inter-core row-transfer link between the two local SFP row sources (core 0 and core 1) and sequences a four-phase req/ack handshake with the remote core. Sits between the per-core `sfp_row` output FIFOs and the cross-core link: it picks one ready source round-robin, drives the link data-mux select, inserts a fixed data-settle pause, raises `req`, waits for `ack`, and supervises the transfer with a timeout.

## Interface

- `SETUP_CYC`, default 4: cycles spent in SETUP before `req` rises. Legal range 1..255.
- `TIMEOUT`, default 255: maximum cycles in WAIT without `ack` before abort. 0 disables the timeout.
- `CNT_W`, default 8: width of the shared setup/timeout counter. Must hold max(SETUP_CYC, TIMEOUT).

- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ready` in 2: bit i high = source i has a row available (its FIFO's `!o_empty`). Level signal.
- `ack` in 1: acknowledge from remote core. Four-phase.
- `req` out 1: request to remote core.
- `gnt` out 2: one-hot grant to the source being transferred.
- `sel` out 1: link data-mux select, index of the granted source.
- `done` out 2: one-cycle pulse to source i on successful transfer (pops its FIFO).
- `busy` out 1: high whenever state != IDLE.
- `timeout_err` out 1: sticky abort flag.
- `clr_err` in 1: synchronous clear of `timeout_err`.

## Operation

- States: IDLE, SETUP, WAIT, RELEASE. Registered state, counter `cnt` (CNT_W bits), round-robin pointer `last` (1 bit), `sel`, `timeout_err`.
- IDLE: if `ready` != 0, choose the winner. If both bits are set, the winner is `!last`; otherwise it is the single set bit. Load `sel`, clear `cnt`, and go to SETUP. If `ready` == 0, stay in IDLE.
- `ready` is sampled only in IDLE. Once granted, the transfer runs to completion or timeout even if `ready` drops.
- SETUP: `cnt` increments each cycle. When `cnt` == SETUP_CYC-1, clear `cnt` and go to WAIT. SETUP lasts exactly SETUP_CYC cycles.
- WAIT: `req` = 1.
  - If `ack` = 1: pulse `done[sel]`, set `last` <= `sel`, go to RELEASE.
  - Else if TIMEOUT != 0 and `cnt` == TIMEOUT-1: set `timeout_err`, set `last` <= `sel`, and go to RELEASE without `done`.
  - Otherwise `cnt` increments.
- RELEASE: `req` = 0. Stay until `ack` = 0, then go to IDLE.
- `gnt` = one-hot(`sel`) in SETUP and WAIT, and 0 otherwise. `req` = (state == WAIT).
- `timeout_err`: set has priority over `clr_err` in the same cycle. Otherwise `clr_err` clears it.
- Reset (asserted low, at any time, including mid-transfer): state = IDLE, `cnt` = 0, `last` = 1 (core 0 wins the first contention), `sel` = 0, `timeout_err` = 0.
- Reset values of outputs: `req` = 0, `gnt` = 0, `done` = 0, `busy` = 0, `timeout_err` = 0, `sel` = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `ack` or `ready` to any output.

## Timing

- `ready` first seen high in IDLE at edge t: state is SETUP from t+1, and `gnt`, `sel`, and `busy` are valid from t+1.
- `req` rises at t+1+SETUP_CYC. Request latency is SETUP_CYC+1 cycles.
- `ack` sampled high in WAIT at edge k: `req` low, `done` high, and `gnt` low from k+1. `done` lasts exactly one cycle.
- RELEASE with `ack` sampled low at edge m: IDLE from m+1, and a new grant is possible at m+2.
- Minimum transfer period (`ack` returns immediately and drops immediately) is SETUP_CYC+4 cycles.
- Timeout: with no `ack`, `req` is high for exactly TIMEOUT cycles. `timeout_err` rises in the same cycle that `req` falls.
- `ack` high on the same edge as timeout expiry: `ack` wins. The result is `done` with no error.
- `ack` already high on entry to WAIT: accepted on the first WAIT cycle, so `req` is high for 1 cycle.
- `ack` still high after a timeout: remain in RELEASE until it drops.

## Test plan

- Reset, then `ready` = 01 at cycle 0 with `ack` tied back one cycle after `req` → `gnt` = 01 at cycle 1, `req` high at cycle 5 (SETUP_CYC = 4), `done` = 01 pulse one cycle after `ack`, and `busy` returns low after `ack` drops.
- `ready` = 11 held with immediate acks → grants alternate 01, 10, 01, 10. Core 0 wins first after reset. Transfers are spaced SETUP_CYC+4 = 8 cycles apart.
- TIMEOUT = 16 with `ack` never asserted → `req` high for exactly 16 cycles, then `timeout_err` = 1 with no `done`. With `ready` = 11, the next grant goes to the other source. `clr_err` pulse → `timeout_err` = 0.
- `ack` rising on the exact expiry cycle → `done` pulses and `timeout_err` stays 0. Separately, `clr_err` asserted on the expiry cycle → `timeout_err` = 1.
- `ready` dropped during SETUP → transfer still completes with `req` and `done`. `ack` held high for 10 cycles after `req` drops → state stays in RELEASE and `busy` = 1 until `ack` falls.
- `reset` driven low asynchronously mid-WAIT → `req`, `gnt`, and `busy` go to 0 immediately without a clock edge. After release, the first contention with `ready` = 11 grants core 0.
